// File: rtl/freq_meter.sv
// Period meter: times rising edges of a slow async square wave in core-clock cycles,
// averages 2^AVG_LOG2 periods per result, strobes valid_out, flags loss of signal.
module freq_meter #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 50000,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk_1m_in,
  input  logic             reset_b,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period_out,
  output logic             valid_out,
  output logic             timeout_out
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int NS_W  = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [NS_W-1:0]  NS_FULL  = NS_W'(1 << AVG_LOG2);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t state, state_nxt;

  logic sync1, sync2, prev;
  logic rise;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [NS_W-1:0]  nsamp, nsamp_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;

  logic [CNT_W-1:0] sample;
  logic [ACC_W-1:0] acc_sum;
  logic [NS_W-1:0]  nsamp_inc;
  logic             cnt_last;

  // Synchronizer and prev run in every state so enabling with sig_in high sees no edge.
  always_ff @(posedge clk_1m_in) begin
    if (!reset_b) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise      = sync2 & ~prev;
  assign sample    = cnt + CNT_W'(1);
  assign acc_sum   = acc + ACC_W'(sample);
  assign nsamp_inc = nsamp + NS_W'(1);
  assign cnt_last  = (cnt == CNT_LAST);

  always_ff @(posedge clk_1m_in) begin
    if (!reset_b) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      nsamp       <= '0;
      period_out  <= '0;
      valid_out   <= 1'b0;
      timeout_out <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      acc         <= acc_nxt;
      nsamp       <= nsamp_nxt;
      period_out  <= period_nxt;
      valid_out   <= valid_nxt;
      timeout_out <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    acc_nxt     = acc;
    nsamp_nxt   = nsamp;
    period_nxt  = period_out;
    valid_nxt   = 1'b0;
    timeout_nxt = timeout_out;

    if (!enable) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      acc_nxt     = '0;
      nsamp_nxt   = '0;
      timeout_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt     = '0;
          acc_nxt     = '0;
          nsamp_nxt   = '0;
          timeout_nxt = 1'b0;
          state_nxt   = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_nxt   = '0;
            state_nxt = MEASURE;
          end else if (cnt_last) begin
            timeout_nxt = 1'b1;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = sample;
          end
        end
        MEASURE: begin
          // An edge on the timeout cycle wins: a period of exactly TIMEOUT is a valid sample.
          if (rise) begin
            cnt_nxt = '0;
            if (nsamp_inc == NS_FULL) begin
              period_nxt  = CNT_W'(acc_sum >> AVG_LOG2);
              valid_nxt   = 1'b1;
              timeout_nxt = 1'b0;
              acc_nxt     = '0;
              nsamp_nxt   = '0;
            end else begin
              acc_nxt   = acc_sum;
              nsamp_nxt = nsamp_inc;
            end
          end else if (cnt_last) begin
            timeout_nxt = 1'b1;
            acc_nxt     = '0;
            nsamp_nxt   = '0;
            cnt_nxt     = '0;
            state_nxt   = ARM;
          end else begin
            cnt_nxt = sample;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: three instances (60 Hz, truncation/loss/enable, TIMEOUT=200 AVG=1)
// driven in parallel; every valid_out is scored against an expected period/timeout/cycle queue.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int TMO = 50000;

  typedef struct {
    int period;
    int tmo;
    int cyc;
  } exp_t;

  logic clk;
  logic reset_b;
  logic sig [3];
  logic enable_a, enable_b, enable_c;
  logic [15:0] per_a, per_b, per_c;
  logic vld_a, vld_b, vld_c;
  logic tmo_a, tmo_b, tmo_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise [3];
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  logic c_win = 1'b0;
  logic c_tmo_seen = 1'b0;

  freq_meter dut_a (
    .clk_1m_in(clk), .reset_b(reset_b), .sig_in(sig[0]), .enable(enable_a),
    .period_out(per_a), .valid_out(vld_a), .timeout_out(tmo_a)
  );

  freq_meter dut_b (
    .clk_1m_in(clk), .reset_b(reset_b), .sig_in(sig[1]), .enable(enable_b),
    .period_out(per_b), .valid_out(vld_b), .timeout_out(tmo_b)
  );

  freq_meter #(.CNT_W(16), .TIMEOUT(200), .AVG_LOG2(0)) dut_c (
    .clk_1m_in(clk), .reset_b(reset_b), .sig_in(sig[2]), .enable(enable_c),
    .period_out(per_c), .valid_out(vld_c), .timeout_out(tmo_c)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected result for the edge being driven now: it is acted on 3 clocks later.
  task automatic push(input int idx, input int p, input int t);
    exp_t e;
    e.period = p;
    e.tmo    = t;
    e.cyc    = cyc + 3;
    case (idx)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic score(input int idx, input logic [15:0] p, input logic t);
    exp_t e;
    logic have;
    string nm;
    have = 1'b0;
    e.period = 0;
    e.tmo = 0;
    e.cyc = 0;
    case (idx)
      0:       begin nm = "a"; if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end end
      1:       begin nm = "b"; if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end end
      default: begin nm = "c"; if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end end
    endcase
    chk({nm, "_strobe_expected"}, {31'd0, have}, 32'd1);
    if (have) begin
      chk({nm, "_period"}, {16'd0, p}, e.period);
      chk({nm, "_timeout_at_valid"}, {31'd0, t}, e.tmo);
      chk({nm, "_valid_cycle"}, cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (vld_a) score(0, per_a, tmo_a);
    if (vld_b) score(1, per_b, tmo_b);
    if (vld_c) score(2, per_c, tmo_c);
    if (c_win && tmo_c) c_tmo_seen = 1'b1;
  end

  task automatic period(input int idx, input int p);
    sig[idx] = 1'b1;
    last_rise[idx] = cyc;
    repeat (p / 2) @(negedge clk);
    sig[idx] = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  initial begin
    int tgt;
    reset_b  = 1'b0;
    sig[0]   = 1'b0;
    sig[1]   = 1'b0;
    sig[2]   = 1'b0;
    enable_a = 1'b1;
    enable_b = 1'b1;
    enable_c = 1'b0;

    // Reset held 3 cycles with inputs toggling every cycle.
    repeat (3) begin
      @(negedge clk);
      chk("rst_per_a", {16'd0, per_a}, 0);
      chk("rst_vld_a", {31'd0, vld_a}, 0);
      chk("rst_tmo_a", {31'd0, tmo_a}, 0);
      chk("rst_per_b", {16'd0, per_b}, 0);
      chk("rst_vld_b", {31'd0, vld_b}, 0);
      chk("rst_tmo_b", {31'd0, tmo_b}, 0);
      chk("rst_per_c", {16'd0, per_c}, 0);
      chk("rst_tmo_c", {31'd0, tmo_c}, 0);
      sig[0] = ~sig[0];
      sig[1] = ~sig[1];
      sig[2] = ~sig[2];
    end
    @(negedge clk);
    reset_b = 1'b1;
    sig[0] = 1'b0;
    sig[1] = 1'b0;
    sig[2] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_vld_a", {31'd0, vld_a}, 0);
      chk("post_rst_vld_b", {31'd0, vld_b}, 0);
    end

    fork
      begin
        // 60 Hz stepdown: arming edge plus four 16668-cycle periods.
        repeat (4) period(0, 16668);
        push(0, 16668, 0);
        period(0, 20);
        repeat (10) @(negedge clk);
        chk("a_timeout_low", {31'd0, tmo_a}, 0);
      end
      begin
        // Truncation: 1000+1001+1001+1001 = 4003, >>2 = 1000.
        period(1, 1000);
        repeat (3) period(1, 1001);
        push(1, 1000, 0);
        period(1, 1000);
        // Two more samples, then the signal is lost.
        period(1, 1000);
        period(1, 1000);
        tgt = last_rise[1] + 2 + TMO;
        while (cyc < tgt) @(negedge clk);
        chk("b_timeout_before_limit", {31'd0, tmo_b}, 0);
        @(negedge clk);
        chk("b_timeout_at_limit", {31'd0, tmo_b}, 1);
        // Recovery: arming edge plus four 1000-cycle periods.
        repeat (4) period(1, 1000);
        chk("b_timeout_held_until_valid", {31'd0, tmo_b}, 1);
        push(1, 1000, 0);
        period(1, 1000);
        // Enable drop after two partial samples; re-enable with the input already high.
        period(1, 1000);
        period(1, 1000);
        enable_b = 1'b0;
        repeat (5) @(negedge clk);
        sig[1] = 1'b1;
        repeat (20) @(negedge clk);
        chk("b_idle_period_held", {16'd0, per_b}, 1000);
        chk("b_idle_timeout_low", {31'd0, tmo_b}, 0);
        enable_b = 1'b1;
        repeat (300) @(negedge clk);
        sig[1] = 1'b0;
        repeat (200) @(negedge clk);
        repeat (4) period(1, 1000);
        push(1, 1000, 0);
        period(1, 20);
        repeat (10) @(negedge clk);
      end
      begin
        // Boundary: TIMEOUT=200, one sample per result, period exactly 200.
        repeat (5) @(negedge clk);
        enable_c = 1'b1;
        c_win = 1'b1;
        repeat (2) @(negedge clk);
        period(2, 200);
        repeat (6) begin
          push(2, 200, 0);
          period(2, 200);
        end
        c_win = 1'b0;
        enable_c = 1'b0;
        chk("c_timeout_held_low", {31'd0, c_tmo_seen}, 0);
      end
    join

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qc_drained", qc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the period of a slow external square wave, such as a comparator-squared DTMF tone or a 60 Hz stepdown clock, in cycles of the 1 MHz system clock. The incoming signal is synchronized into the clock domain, and the block times consecutive rising edges. It averages 2^AVG_LOG2 periods and presents the result with a one-cycle valid strobe. A timeout flag reports that no signal is present. The block is the measuring counterpart to the board's clock stepdown dividers, and it feeds the DTMF tone-classification logic.

## Interface
- CNT_W, 16: width of the period counter and of `period_out`.
- TIMEOUT, 50000: the number of cycles without a rising edge that declares the signal lost. Legal range is 2..2^CNT_W-1.
- AVG_LOG2, 2: log2 of the number of periods averaged per result. Legal range is 0..4.
- clk_1m_in, input, 1: the 1 MHz clock. The block has one clock, and all logic is on the rising edge.
- reset_b, input, 1: reset, synchronous and active-low.
- sig_in, input, 1: the asynchronous square wave to be measured.
- enable, input, 1: the block measures while this is high. Low forces IDLE.
- period_out, output, CNT_W: the latest averaged period, in clk_1m_in cycles.
- valid_out, output, 1: a one-cycle pulse when `period_out` updates.
- timeout_out, output, 1: a level signal, high while the signal is considered lost.

## Operation
- **Input path:** a 2-FF synchronizer feeds a previous-value register. A rising edge is recognized when sync2=1 and prev=0. The synchronizer and prev register always run, including in IDLE, so enabling while `sig_in` is already high never produces a false edge.
- **IDLE state:**
  - On entry, the cycle counter, accumulator and sample count are cleared, and `timeout_out` is cleared.
  - `period_out` holds its value.
  - The state moves to ARM when `enable`=1.
- **ARM state:**
  - The counter increments every cycle.
  - A rising edge sets counter <= 0 and moves the state to MEASURE.
  - If no edge arrives and counter == TIMEOUT-1, then `timeout_out` <= 1, the counter restarts at 0, and the state stays in ARM.
- **MEASURE state:**
  - The counter increments every cycle.
  - On a rising edge, sample = counter+1, acc <= acc+sample, nsamp <= nsamp+1, and counter <= 0.
  - When nsamp reaches 2^AVG_LOG2:
    - period_out <= (acc+sample) >> AVG_LOG2, truncating.
    - valid_out <= 1 and timeout_out <= 0.
    - acc and nsamp are cleared.
    - The state stays in MEASURE, so periods are measured back to back.
  - If no edge arrives and counter == TIMEOUT-1, then `timeout_out` <= 1, acc, nsamp and counter are cleared, and the state moves to ARM.
- **Edge coinciding with timeout:** the edge wins. A period of exactly TIMEOUT is a valid sample and sets no timeout.
- **enable low in any state:** the block returns to IDLE on the next clock and discards any partial accumulation. No `valid_out` is produced.
- **Widths:**
  - The accumulator is CNT_W+AVG_LOG2 bits, so it cannot overflow because each sample is at most TIMEOUT.
  - The counter never wraps, because timeout fires first.

## Timing
- **Reset:** while `reset_b`=0 at a clock edge, the following all go to 0 and the state goes to IDLE:
  - period_out, valid_out and timeout_out;
  - the synchronizer and prev registers;
  - the counter, the accumulator and nsamp.
- **Edge recognition latency:** an edge is recognized 2 clocks after `sig_in` is first sampled high. This latency is constant, so it cancels in the period.
- **Period accuracy:** a square wave of period P cycles yields sample = P exactly, with ±1 jitter only from asynchronous sampling.
- **valid_out timing:** `valid_out` is high for exactly the one cycle after the edge at which the 2^AVG_LOG2-th sample is taken. `period_out` is stable from that cycle onward until the next strobe.
- **First result:** the first result appears 1 arming edge plus 2^AVG_LOG2 periods after entering ARM.
- **timeout_out timing:** `timeout_out` rises exactly TIMEOUT cycles after the last recognized edge, or after ARM entry. It falls with the next `valid_out`, or when IDLE is entered.

## Test plan
- **Reset:** hold `reset_b`=0 for 3 cycles with `sig_in` toggling every cycle. Required: period_out=0, valid_out=0 and timeout_out=0 throughout, and no strobe during the first 2 cycles after release.
- **60 Hz input:** drive a square wave of period 16668 cycles (the 60 Hz stepdown output) with defaults. Required: one `valid_out` per 4 periods with period_out=16668, and timeout_out=0.
- **Averaging truncation:** drive periods of 1000, 1001, 1001 and 1001 cycles. Required: period_out=1000 (4003>>2) with one `valid_out` pulse.
- **Loss and recovery:** run a 1000-cycle wave, then hold `sig_in` low. Required:
  - timeout_out=1 exactly 50000 cycles after the last recognized edge, and no `valid_out`.
  - On resuming the 1000-cycle wave, timeout_out=0 on the first `valid_out`, with period_out=1000.
- **Enable drop:** deassert `enable` after 2 periods, then reassert it with `sig_in` already high. Required: no strobe for the partial set, no false edge, and the next `valid_out` after 1 arming edge plus 4 periods.
- **Boundary:** set TIMEOUT=200 and AVG_LOG2=0, and drive a period of exactly 200. Required: valid_out on every edge with period_out=200, and timeout_out held at 0.
